mem_stage_ctrl: RTL and testbench

- Consumer end of the EX/MEM pipeline register: takes its registered outputs and executes the MEM stage.
- Resolves branch/jump redirect, runs a multi-cycle data-memory request/acknowledge handshake, and stalls upstream while an access is pending.
- Drives registered MEM/WB outputs (write-back data, rd, control) toward the WB stage.

---
 rtl/mem_stage_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: branch redirect, data-memory req/ack handshake, upstream stall, MEM/WB register.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
`timescale 1ns/1ps
module mem_stage_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk_EXMem,
    input  logic              rst_EXMem,
    input  logic              valid_in,
    input  logic [31:0]       ALU_in,
    input  logic [31:0]       Rs2_in,
    input  logic [31:0]       PC4_in,
    input  logic [31:0]       PC_imm_in,
    input  logic              zero_in,
    input  logic              Branch_in,
    input  logic              BranchN_in,
    input  logic              Jump_in,
    input  logic              MemRW_in,
    input  logic [1:0]        MemtoReg_in,
    input  logic              RegWrite_in,
    input  logic [4:0]        Rd_addr_in,
    input  logic [31:0]       inst_in,
    input  logic [31:0]       pc_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              stall_out,
    output logic              redirect,
    output logic [31:0]       redirect_pc,
    output logic              wb_valid,
    output logic              wb_regwrite,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic [31:0]       wb_inst,
    output logic [31:0]       wb_pc,
    output logic              mem_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      r_state;

    logic        r_pendLoad;
    logic        r_pendRegWrite;
    logic [4:0]  r_pendRd;
    logic [31:0] r_pendData;
    logic [31:0] r_pendInst;
    logic [31:0] r_pendPc;

    logic        w_memOp;
    logic        w_taken;
    logic [31:0] w_selData;

    assign w_memOp = valid_in & (MemRW_in | (MemtoReg_in == 2'b01));
    assign w_taken = valid_in & (Jump_in | (Branch_in & zero_in) | (BranchN_in & ~zero_in));

    // Load data (01) only arrives through the ACCESS path, so it falls to the ALU default here.
    always_comb begin
        w_selData = ALU_in;
        case (MemtoReg_in)
            2'b10:   w_selData = PC4_in;
            2'b11:   w_selData = PC_imm_in;
            default: w_selData = ALU_in;
        endcase
    end

    // Stall drops in the ack cycle so EX/MEM advances on the same edge the access completes.
    always_comb begin
        stall_out = 1'b0;
        if (!rst_EXMem) begin
            stall_out = ((r_state == IDLE) & w_memOp) | ((r_state == ACCESS) & ~dmem_ack);
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] r_timeoutCnt;
`else
    assign mem_err = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk_EXMem or posedge rst_EXMem) begin
        if (rst_EXMem) begin
            r_state        <= IDLE;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            redirect       <= 1'b0;
            redirect_pc    <= '0;
            wb_valid       <= 1'b0;
            wb_regwrite    <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            wb_inst        <= '0;
            wb_pc          <= '0;
            r_pendLoad     <= 1'b0;
            r_pendRegWrite <= 1'b0;
            r_pendRd       <= '0;
            r_pendData     <= '0;
            r_pendInst     <= '0;
            r_pendPc       <= '0;
`ifdef MEM_TIMEOUT_EN
            r_timeoutCnt   <= '0;
            mem_err        <= 1'b0;
`endif
        end else begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            redirect    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            mem_err     <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_memOp) begin
                        r_state        <= ACCESS;
                        dmem_req       <= 1'b1;
                        dmem_we        <= MemRW_in;
                        dmem_addr      <= {ALU_in[ADDR_W-1:2], 2'b00};
                        dmem_wdata     <= Rs2_in;
                        r_pendLoad     <= (MemtoReg_in == 2'b01);
                        r_pendRegWrite <= RegWrite_in;
                        r_pendRd       <= Rd_addr_in;
                        r_pendData     <= w_selData;
                        r_pendInst     <= inst_in;
                        r_pendPc       <= pc_in;
`ifdef MEM_TIMEOUT_EN
                        r_timeoutCnt   <= '0;
`endif
                    end else if (valid_in) begin
                        wb_valid    <= 1'b1;
                        wb_regwrite <= RegWrite_in;
                        wb_rd       <= Rd_addr_in;
                        wb_data     <= w_selData;
                        wb_inst     <= inst_in;
                        wb_pc       <= pc_in;
                        if (w_taken) begin
                            redirect    <= 1'b1;
                            redirect_pc <= PC_imm_in;
                        end
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        r_state     <= IDLE;
                        dmem_req    <= 1'b0;
                        dmem_we     <= 1'b0;
                        wb_valid    <= 1'b1;
                        wb_regwrite <= r_pendRegWrite;
                        wb_rd       <= r_pendRd;
                        wb_data     <= r_pendLoad ? dmem_rdata : r_pendData;
                        wb_inst     <= r_pendInst;
                        wb_pc       <= r_pendPc;
`ifdef MEM_TIMEOUT_EN
                    end else if (r_timeoutCnt == CNT_LAST) begin
                        // Abandoned access still retires so the pipeline drains, but never writes a register.
                        r_state     <= IDLE;
                        dmem_req    <= 1'b0;
                        dmem_we     <= 1'b0;
                        mem_err     <= 1'b1;
                        wb_valid    <= 1'b1;
                        wb_regwrite <= 1'b0;
                        wb_rd       <= r_pendRd;
                        wb_data     <= '0;
                        wb_inst     <= r_pendInst;
                        wb_pc       <= r_pendPc;
                    end else begin
                        r_timeoutCnt <= r_timeoutCnt + 1'b1;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed steps plus randomized instruction stream
// checked against a per-instruction reference model.
`timescale 1ns/1ps
module tb_mem_stage_ctrl;

    localparam int TB_TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [31:0] ALU_in, Rs2_in, PC4_in, PC_imm_in, inst_in, pc_in;
    logic        zero_in, Branch_in, BranchN_in, Jump_in, MemRW_in, RegWrite_in;
    logic [1:0]  MemtoReg_in;
    logic [4:0]  Rd_addr_in;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall_out, redirect, wb_valid, wb_regwrite, mem_err;
    logic [31:0] redirect_pc, wb_data, wb_inst, wb_pc;
    logic [4:0]  wb_rd;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    typedef struct {
        bit          valid;
        bit          memRW;
        logic [1:0]  memtoReg;
        bit          regWrite;
        logic [4:0]  rd;
        logic [31:0] alu, rs2, pc4, pcImm, inst, pc;
        bit          zero, branch, branchN, jump;
        int          ackDelay;
        logic [31:0] rdata;
    } instr_t;

    mem_stage_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk_EXMem(clk), .rst_EXMem(rst), .valid_in(valid_in),
        .ALU_in(ALU_in), .Rs2_in(Rs2_in), .PC4_in(PC4_in), .PC_imm_in(PC_imm_in),
        .zero_in(zero_in), .Branch_in(Branch_in), .BranchN_in(BranchN_in), .Jump_in(Jump_in),
        .MemRW_in(MemRW_in), .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
        .Rd_addr_in(Rd_addr_in), .inst_in(inst_in), .pc_in(pc_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_out(stall_out),
        .redirect(redirect), .redirect_pc(redirect_pc), .wb_valid(wb_valid),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data), .wb_inst(wb_inst),
        .wb_pc(wb_pc), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input instr_t t);
        valid_in    = t.valid;
        ALU_in      = t.alu;
        Rs2_in      = t.rs2;
        PC4_in      = t.pc4;
        PC_imm_in   = t.pcImm;
        zero_in     = t.zero;
        Branch_in   = t.branch;
        BranchN_in  = t.branchN;
        Jump_in     = t.jump;
        MemRW_in    = t.memRW;
        MemtoReg_in = t.memtoReg;
        RegWrite_in = t.regWrite;
        Rd_addr_in  = t.rd;
        inst_in     = t.inst;
        pc_in       = t.pc;
    endtask

    function automatic bit isMemOp(input instr_t t);
        return t.valid && (t.memRW || t.memtoReg == 2'b01);
    endfunction

    function automatic bit isTaken(input instr_t t);
        return t.valid && (t.jump || (t.branch && t.zero) || (t.branchN && !t.zero));
    endfunction

    function automatic logic [31:0] expWbData(input instr_t t);
        case (t.memtoReg)
            2'b00:   return t.alu;
            2'b01:   return t.rdata;
            2'b10:   return t.pc4;
            default: return t.pcImm;
        endcase
    endfunction

    function automatic instr_t blankInstr();
        instr_t t;
        t = '{default: 0};
        return t;
    endfunction

    function automatic instr_t randInstr();
        instr_t t;
        int kind;
        int m;
        t          = blankInstr();
        t.valid    = ($urandom_range(0, 9) != 0);
        t.alu      = $urandom;
        t.rs2      = $urandom;
        t.pc4      = $urandom;
        t.pcImm    = $urandom;
        t.inst     = $urandom;
        t.pc       = $urandom;
        t.rd       = 5'($urandom_range(0, 31));
        t.zero     = 1'($urandom_range(0, 1));
        t.regWrite = 1'($urandom_range(0, 1));
        t.rdata    = $urandom;
        t.ackDelay = $urandom_range(0, TB_TIMEOUT - 1);
        kind       = $urandom_range(0, 3);
        m          = $urandom_range(0, 2);
        case (kind)
            0, 1: begin
                t.memtoReg = (m == 0) ? 2'b00 : 2'(m + 1);
                if (kind == 1) begin
                    t.branch  = 1'($urandom_range(0, 1));
                    t.branchN = 1'($urandom_range(0, 1));
                    t.jump    = 1'($urandom_range(0, 1));
                end
            end
            2: t.memtoReg = 2'b01;
            default: begin
                t.memRW    = 1'b1;
                t.regWrite = 1'b0;
            end
        endcase
        if (!t.valid) begin
            t.memRW    = 1'($urandom_range(0, 1));
            t.memtoReg = 2'($urandom_range(0, 3));
        end
        return t;
    endfunction

    // Drives one EX/MEM slot to retirement; must be entered at posedge+1.
    task automatic runInstr(input instr_t t, input bit spuriousAck);
        applyStimulus(t);
        if (!isMemOp(t)) begin
            dmem_ack   = spuriousAck;
            dmem_rdata = $urandom;
            #1;
            checkOutput("stall_nonmem", stall_out, 0);
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            checkOutput("req_nonmem", dmem_req, 0);
            checkOutput("wb_valid", wb_valid, t.valid);
            checkOutput("wb_regwrite", wb_regwrite, t.valid & t.regWrite);
            checkOutput("redirect", redirect, isTaken(t));
            if (t.valid) begin
                checkOutput("wb_rd", wb_rd, t.rd);
                checkOutput("wb_data", wb_data, expWbData(t));
                checkOutput("wb_inst", wb_inst, t.inst);
                checkOutput("wb_pc", wb_pc, t.pc);
            end
            if (isTaken(t)) checkOutput("redirect_pc", redirect_pc, t.pcImm);
        end else begin
            #1;
            checkOutput("stall_issue", stall_out, 1);
            @(posedge clk); #1;
            checkOutput("req_on", dmem_req, 1);
            checkOutput("req_we", dmem_we, t.memRW);
            checkOutput("req_addr", dmem_addr, {t.alu[31:2], 2'b00});
            checkOutput("req_wdata", dmem_wdata, t.rs2);
            checkOutput("wb_valid_issue", wb_valid, 0);
            checkOutput("redirect_issue", redirect, 0);
            for (int k = 0; k < t.ackDelay; k++) begin
                checkOutput("stall_wait", stall_out, 1);
                @(posedge clk); #1;
                checkOutput("req_held", dmem_req, 1);
                checkOutput("addr_held", dmem_addr, {t.alu[31:2], 2'b00});
                checkOutput("wb_valid_wait", wb_valid, 0);
                checkOutput("mem_err_wait", mem_err, 0);
            end
            dmem_ack   = 1'b1;
            dmem_rdata = t.rdata;
            #1;
            checkOutput("stall_ack", stall_out, 0);
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            checkOutput("req_off", dmem_req, 0);
            checkOutput("wb_valid_mem", wb_valid, 1);
            checkOutput("wb_regwrite_mem", wb_regwrite, t.regWrite);
            checkOutput("wb_rd_mem", wb_rd, t.rd);
            checkOutput("wb_inst_mem", wb_inst, t.inst);
            checkOutput("wb_pc_mem", wb_pc, t.pc);
            checkOutput("redirect_mem", redirect, 0);
            checkOutput("mem_err_mem", mem_err, 0);
            if (t.memtoReg == 2'b01) checkOutput("wb_data_load", wb_data, t.rdata);
        end
    endtask

    task automatic checkAllZero(input string phase);
        checkOutput({phase, "_req"}, dmem_req, 0);
        checkOutput({phase, "_we"}, dmem_we, 0);
        checkOutput({phase, "_addr"}, dmem_addr, 0);
        checkOutput({phase, "_wdata"}, dmem_wdata, 0);
        checkOutput({phase, "_stall"}, stall_out, 0);
        checkOutput({phase, "_redirect"}, redirect, 0);
        checkOutput({phase, "_redirect_pc"}, redirect_pc, 0);
        checkOutput({phase, "_wb_valid"}, wb_valid, 0);
        checkOutput({phase, "_wb_regwrite"}, wb_regwrite, 0);
        checkOutput({phase, "_wb_rd"}, wb_rd, 0);
        checkOutput({phase, "_wb_data"}, wb_data, 0);
        checkOutput({phase, "_wb_inst"}, wb_inst, 0);
        checkOutput({phase, "_wb_pc"}, wb_pc, 0);
        checkOutput({phase, "_mem_err"}, mem_err, 0);
    endtask

    initial begin
        instr_t t;
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        applyStimulus(blankInstr());
        #1;
        checkAllZero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] ALU op");
        t = blankInstr();
        t.valid = 1; t.alu = 32'h1234; t.regWrite = 1; t.rd = 5; t.inst = 32'h0000_0013; t.pc = 32'h10;
        runInstr(t, 1'b0);

        $display("[TB] load with three stall cycles");
        t = blankInstr();
        t.valid = 1; t.alu = 32'h103; t.memtoReg = 2'b01; t.regWrite = 1; t.rd = 7;
        t.ackDelay = 2; t.rdata = 32'hDEADBEEF; t.pc = 32'h14;
        runInstr(t, 1'b0);

        $display("[TB] store then back-to-back ALU op");
        t = blankInstr();
        t.valid = 1; t.alu = 32'h40; t.rs2 = 32'hA5A5A5A5; t.memRW = 1; t.ackDelay = 0; t.pc = 32'h18;
        runInstr(t, 1'b0);
        t = blankInstr();
        t.valid = 1; t.pc4 = 32'h20; t.memtoReg = 2'b10; t.regWrite = 1; t.rd = 1; t.pc = 32'h1C;
        runInstr(t, 1'b0);

        $display("[TB] BranchN taken, then not taken");
        t = blankInstr();
        t.valid = 1; t.branchN = 1; t.zero = 0; t.pcImm = 32'h80; t.pc = 32'h24;
        runInstr(t, 1'b1);
        runInstr(blankInstr(), 1'b0);
        t.zero = 1;
        runInstr(t, 1'b0);

        $display("[TB] reset during ACCESS");
        t = blankInstr();
        t.valid = 1; t.alu = 32'h200; t.memtoReg = 2'b01; t.regWrite = 1; t.rd = 3;
        applyStimulus(t);
        @(posedge clk); #1;
        checkOutput("pre_reset_req", dmem_req, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkAllZero("midreset");
        applyStimulus(blankInstr());
        @(posedge clk); #1;
        rst      = 1'b0;
        dmem_ack = 1'b1;
        #1;
        checkOutput("late_ack_stall", stall_out, 0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        checkOutput("late_ack_req", dmem_req, 0);
        checkOutput("late_ack_wb_valid", wb_valid, 0);

`ifdef MEM_TIMEOUT_EN
        $display("[TB] access timeout");
        t = blankInstr();
        t.valid = 1; t.alu = 32'h300; t.memtoReg = 2'b01; t.regWrite = 1; t.rd = 9;
        applyStimulus(t);
        @(posedge clk); #1;
        for (int k = 1; k <= TB_TIMEOUT; k++) begin
            checkOutput("to_stall", stall_out, 1);
            @(posedge clk); #1;
            if (k < TB_TIMEOUT) checkOutput("to_req_held", dmem_req, 1);
        end
        checkOutput("to_mem_err", mem_err, 1);
        checkOutput("to_req_off", dmem_req, 0);
        checkOutput("to_wb_valid", wb_valid, 1);
        checkOutput("to_wb_regwrite", wb_regwrite, 0);
        t = blankInstr();
        t.valid = 1; t.alu = 32'h55; t.regWrite = 1; t.rd = 2;
        runInstr(t, 1'b0);
        checkOutput("to_mem_err_pulse", mem_err, 0);
`else
        $display("[TB] long access without timeout");
        t = blankInstr();
        t.valid = 1; t.alu = 32'h300; t.memtoReg = 2'b01; t.regWrite = 1; t.rd = 9;
        t.ackDelay = 12; t.rdata = 32'h0BAD_F00D;
        runInstr(t, 1'b0);
`endif

        $display("[TB] random instruction stream");
        for (int n = 0; n < 200; n++) begin
            runInstr(randInstr(), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
